// File: rtl/apb_reg_slave_pkg.sv
// Shared types for the APB register slave: APB4 request/response structs
// (built with the common APB typedef macros) and the transfer FSM states.
`ifndef APB_TYPEDEF_REQ_T
`define APB_TYPEDEF_REQ_T(req_t, addr_t, data_t, strb_t) \
    typedef struct packed { \
        addr_t      paddr;   \
        logic [2:0] pprot;   \
        logic       psel;    \
        logic       penable; \
        logic       pwrite;  \
        data_t      pwdata;  \
        strb_t      pstrb;   \
    } req_t;
`endif

`ifndef APB_TYPEDEF_RESP_T
`define APB_TYPEDEF_RESP_T(resp_t, data_t) \
    typedef struct packed { \
        logic  pready;  \
        data_t prdata;  \
        logic  pslverr; \
    } resp_t;
`endif

package apb_reg_slave_pkg;

    localparam int unsigned ApbAddrWidth = 32;
    localparam int unsigned ApbDataWidth = 32;

    typedef logic [ApbAddrWidth-1:0]   apb_addr_t;
    typedef logic [ApbDataWidth-1:0]   apb_data_t;
    typedef logic [ApbDataWidth/8-1:0] apb_strb_t;

    `APB_TYPEDEF_REQ_T(apb_req_t, apb_addr_t, apb_data_t, apb_strb_t)
    `APB_TYPEDEF_RESP_T(apb_rsp_t, apb_data_t)

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } apb_state_e;

endpackage

// File: rtl/apb_reg_decode.sv
// Combinational address decode for the register bank: word index plus a
// single error flag covering misaligned, unmapped and read-only writes.
module apb_reg_decode #(
    parameter int unsigned       NoRegs    = 8,
    parameter int unsigned       AddrWidth = 32,
    parameter int unsigned       DataWidth = 32,
    parameter logic [NoRegs-1:0] ReadOnly  = '0,
    localparam int unsigned      IdxWidth  = (NoRegs > 1) ? $clog2(NoRegs) : 1
) (
    input  logic [AddrWidth-1:0] paddr_i,
    input  logic [AddrWidth-1:0] base_addr_i,
    input  logic                 pwrite_i,
    output logic [IdxWidth-1:0]  idx_o,
    output logic                 err_o
);

    localparam int unsigned          ByteBits = $clog2(DataWidth / 8);
    localparam logic [AddrWidth-1:0] LaneMask = AddrWidth'((64'd1 << ByteBits) - 64'd1);

    logic [AddrWidth-1:0] off;
    logic [AddrWidth-1:0] word;
    logic                 misaligned;
    logic                 unmapped;
    logic                 read_only;

    // Addresses below the base wrap to huge offsets and fall out as unmapped.
    always_comb begin
        off        = paddr_i - base_addr_i;
        word       = off >> ByteBits;
        misaligned = |(off & LaneMask);
        unmapped   = (word >= AddrWidth'(NoRegs));
        idx_o      = word[IdxWidth-1:0];
        read_only  = !unmapped && ReadOnly[idx_o];
        err_o      = misaligned || unmapped || (pwrite_i && read_only);
    end

endmodule

// File: rtl/apb_reg_slave.sv
// APB4 completer with a bank of memory-mapped registers, a fixed number of
// wait states per access, byte strobes, read-only registers and hardware loads.
module apb_reg_slave
    import apb_reg_slave_pkg::*;
#(
    parameter int unsigned                      NoRegs     = 8,
    parameter int unsigned                      AddrWidth  = 32,
    parameter int unsigned                      DataWidth  = 32,
    parameter int unsigned                      WaitStates = 1,
    parameter logic [NoRegs-1:0]                ReadOnly   = '0,
    parameter logic [NoRegs-1:0][DataWidth-1:0] RegRstVal  = '0,
    parameter type                              apb_req_t  = apb_reg_slave_pkg::apb_req_t,
    parameter type                              apb_rsp_t  = apb_reg_slave_pkg::apb_rsp_t
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  apb_req_t                         apb_req_i,
    output apb_rsp_t                         apb_rsp_o,
    input  logic [AddrWidth-1:0]             base_addr_i,
    input  logic [NoRegs-1:0]                reg_load_i,
    input  logic [NoRegs-1:0][DataWidth-1:0] reg_d_i,
    output logic [NoRegs-1:0][DataWidth-1:0] reg_q_o
);

    localparam int unsigned IdxWidth  = (NoRegs > 1) ? $clog2(NoRegs) : 1;
    localparam int unsigned CntWidth  = (WaitStates > 0) ? $clog2(WaitStates + 1) : 1;
    localparam int unsigned StrbWidth = DataWidth / 8;

    apb_state_e                       state_q;
    logic [CntWidth-1:0]              cnt_q;
    logic [IdxWidth-1:0]              idx_q;
    logic                             err_q;
    logic                             write_q;
    logic                             pready_q;
    logic                             pslverr_q;
    logic [DataWidth-1:0]             prdata_q;
    logic [NoRegs-1:0][DataWidth-1:0] regs_q;
    logic [NoRegs-1:0][DataWidth-1:0] regs_d;

    logic [IdxWidth-1:0] dec_idx;
    logic [IdxWidth-1:0] sel_idx;
    logic                dec_err;
    logic                sel_err;
    logic                sel_write;
    logic                setup;
    logic                enter_resp;
    logic                apb_commit;
    logic                unused_pprot;

    function automatic logic [DataWidth-1:0] merge_strb(
        input logic [DataWidth-1:0] old_v,
        input logic [DataWidth-1:0] new_v,
        input logic [StrbWidth-1:0] strb
    );
        logic [DataWidth-1:0] res;
        res = old_v;
        for (int k = 0; k < StrbWidth; k++) begin
            if (strb[k]) res[8*k +: 8] = new_v[8*k +: 8];
        end
        return res;
    endfunction

    apb_reg_decode #(
        .NoRegs    (NoRegs),
        .AddrWidth (AddrWidth),
        .DataWidth (DataWidth),
        .ReadOnly  (ReadOnly)
    ) u_decode (
        .paddr_i     (apb_req_i.paddr),
        .base_addr_i (base_addr_i),
        .pwrite_i    (apb_req_i.pwrite),
        .idx_o       (dec_idx),
        .err_o       (dec_err)
    );

    // With zero wait states the response is prepared straight from the live decode.
    always_comb begin
        setup      = apb_req_i.psel && !apb_req_i.penable;
        sel_idx    = (state_q == StIdle) ? dec_idx : idx_q;
        sel_err    = (state_q == StIdle) ? dec_err : err_q;
        sel_write  = (state_q == StIdle) ? apb_req_i.pwrite : write_q;
        enter_resp = 1'b0;
        unique case (state_q)
            StIdle:   enter_resp = setup && (WaitStates == 0);
            StAccess: enter_resp = apb_req_i.psel && apb_req_i.penable &&
                                   (cnt_q == CntWidth'(WaitStates - 1));
            default:  enter_resp = 1'b0;
        endcase
        apb_commit = (state_q == StResp) && apb_req_i.psel && write_q && !err_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            write_q   <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            pready_q  <= enter_resp;
            pslverr_q <= enter_resp && sel_err;
            prdata_q  <= (enter_resp && !sel_err && !sel_write) ? regs_q[sel_idx] : '0;
            unique case (state_q)
                StIdle: begin
                    if (setup) begin
                        idx_q   <= dec_idx;
                        err_q   <= dec_err;
                        write_q <= apb_req_i.pwrite;
                        cnt_q   <= '0;
                        state_q <= (WaitStates == 0) ? StResp : StAccess;
                    end
                end
                StAccess: begin
                    if (!apb_req_i.psel) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (enter_resp) begin
                        state_q <= StResp;
                        cnt_q   <= '0;
                    end else if (apb_req_i.penable) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Hardware load first, then the APB write overrides only the strobed lanes.
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NoRegs; j++) begin
            if (reg_load_i[j]) regs_d[j] = reg_d_i[j];
            if (apb_commit && (idx_q == IdxWidth'(j))) begin
                regs_d[j] = merge_strb(regs_d[j], apb_req_i.pwdata, apb_req_i.pstrb);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regs_q <= RegRstVal;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        apb_rsp_o         = '0;
        apb_rsp_o.pready  = pready_q;
        apb_rsp_o.prdata  = prdata_q;
        apb_rsp_o.pslverr = pslverr_q;
    end

    assign reg_q_o      = regs_q;
    assign unused_pprot = ^apb_req_i.pprot;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Bench for apb_reg_slave: directed scenarios plus randomized APB traffic
// checked every cycle against a transaction-level register model.
module tb_apb_reg_slave;
    import apb_reg_slave_pkg::*;

    localparam int              NREG = 8;
    localparam int              WS   = 2;
    localparam logic [31:0]     BASE = 32'h0000_4000;
    localparam logic [7:0]      RO   = 8'b0000_0010;
    localparam logic [7:0][31:0] RST = {32'hA000_0007, 32'hA000_0006, 32'hA000_0005, 32'hA000_0004,
                                        32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    apb_req_t        req;
    apb_rsp_t        rsp;
    logic [31:0]     base;
    logic [7:0]      ld;
    logic [7:0][31:0] ldd;
    logic [7:0][31:0] q;

    int n_cmp  = 0;
    int n_fail = 0;

    apb_reg_slave #(
        .NoRegs     (NREG),
        .AddrWidth  (32),
        .DataWidth  (32),
        .WaitStates (WS),
        .ReadOnly   (RO),
        .RegRstVal  (RST)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .apb_req_i   (req),
        .apb_rsp_o   (rsp),
        .base_addr_i (base),
        .reg_load_i  (ld),
        .reg_d_i     (ldd),
        .reg_q_o     (q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level model: register contents plus the one outstanding transfer.
    logic [31:0] mdl [NREG];
    int          cyc;
    bit          t_act;
    bit          t_wr;
    bit          t_err;
    int          t_idx;
    int          t_resp;
    logic [31:0] t_snap;

    task automatic model_start(input logic [31:0] a, input bit wr);
        logic [31:0] off;
        off   = a - BASE;
        t_idx = int'(off >> 2);
        t_wr  = wr;
        if (off[1:0] != 2'b00 || (off >> 2) >= 32'(NREG)) t_err = 1'b1;
        else t_err = wr && RO[t_idx];
        t_resp = cyc + WS + 1;
        t_act  = 1'b1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NREG; j++) mdl[j] = RST[j];
            t_act  = 1'b0;
            t_snap = '0;
            cyc    = 0;
        end else begin
            if (t_act && cyc + 1 == t_resp) t_snap = (t_err || t_wr) ? 32'h0 : mdl[t_idx];
            for (int j = 0; j < NREG; j++) if (ld[j]) mdl[j] = ldd[j];
            if (t_act && cyc == t_resp && t_wr && !t_err && req.psel) begin
                for (int k = 0; k < 4; k++)
                    if (req.pstrb[k]) mdl[t_idx][8*k +: 8] = req.pwdata[8*k +: 8];
            end
            cyc++;
        end
    end

    logic [255:0] mq;
    always @(negedge clk) begin
        for (int j = 0; j < NREG; j++) mq[32*j +: 32] = mdl[j];
        check("reg_q", q, mq);
        if (rst_n && t_act && cyc == t_resp) begin
            check("pready", 256'(rsp.pready), 256'(1));
            check("pslverr", 256'(rsp.pslverr), 256'(t_err));
            check("prdata", 256'(rsp.prdata), 256'(t_snap));
        end else begin
            check("pready_idle", 256'(rsp.pready), 256'(0));
            check("pslverr_idle", 256'(rsp.pslverr), 256'(0));
            check("prdata_idle", 256'(rsp.prdata), 256'(0));
        end
    end

    task automatic apb_xfer(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                            input logic [3:0] st, input logic [7:0] ldm, input logic [31:0] ldv,
                            output logic [31:0] rd, output logic er, output int lat);
        req.paddr   = a;
        req.pwrite  = wr;
        req.pwdata  = wd;
        req.pstrb   = st;
        req.psel    = 1'b1;
        req.penable = 1'b0;
        model_start(a, wr);
        @(posedge clk); #1;
        req.penable = 1'b1;
        lat = 1;
        while (!rsp.pready && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rsp.pready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: no pready for addr %0h", a);
        end
        rd = rsp.prdata;
        er = rsp.pslverr;
        ld = ldm;
        for (int j = 0; j < NREG; j++) ldd[j] = ldv;
        @(posedge clk); #1;
        req.psel    = 1'b0;
        req.penable = 1'b0;
        ld          = '0;
    endtask

    task automatic hw_load(input logic [7:0] m, input logic [31:0] v);
        ld = m;
        for (int j = 0; j < NREG; j++) ldd[j] = v;
        @(posedge clk); #1;
        ld = '0;
    endtask

    logic [31:0]      rd;
    logic             er;
    int               lat;
    logic [7:0][31:0] snap_q;
    logic [31:0]      bad [3];
    logic [31:0]      ra;
    int               sel;

    initial begin
        req   = '0;
        base  = BASE;
        ld    = '0;
        ldd   = '0;
        bad   = '{32'h0000_4002, 32'h0000_4020, 32'h0000_3FFC};
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_q", q, RST);
        check("rst_pready", 256'(rsp.pready), 256'(0));

        // Full-word write then read back, 3 access cycles each
        apb_xfer(32'h4008, 1'b1, 32'hDEAD_BEEF, 4'hF, 8'h0, 32'h0, rd, er, lat);
        check("wr_lat", 256'(lat), 256'(3));
        check("wr_err", 256'(er), 256'(0));
        check("wr_q2", 256'(q[2]), 256'(32'hDEAD_BEEF));
        apb_xfer(32'h4008, 1'b0, 32'h0, 4'h0, 8'h0, 32'h0, rd, er, lat);
        check("rd_lat", 256'(lat), 256'(3));
        check("rd_data", 256'(rd), 256'(32'hDEAD_BEEF));
        check("rd_err", 256'(er), 256'(0));

        // Partial strobes over all-ones
        apb_xfer(32'h400C, 1'b1, 32'hFFFF_FFFF, 4'hF, 8'h0, 32'h0, rd, er, lat);
        apb_xfer(32'h400C, 1'b1, 32'h1122_3344, 4'b0101, 8'h0, 32'h0, rd, er, lat);
        check("strb_q3", 256'(q[3]), 256'(32'hFF22_FF44));
        apb_xfer(32'h400C, 1'b0, 32'h0, 4'h0, 8'h0, 32'h0, rd, er, lat);
        check("strb_rd", 256'(rd), 256'(32'hFF22_FF44));

        // Misaligned, unmapped and below-base addresses
        for (int i = 0; i < 3; i++) begin
            snap_q = q;
            apb_xfer(bad[i], 1'b0, 32'h0, 4'h0, 8'h0, 32'h0, rd, er, lat);
            check("bad_rd_err", 256'(er), 256'(1));
            check("bad_rd_data", 256'(rd), 256'(0));
            apb_xfer(bad[i], 1'b1, 32'h5A5A_5A5A, 4'hF, 8'h0, 32'h0, rd, er, lat);
            check("bad_wr_err", 256'(er), 256'(1));
            check("bad_wr_q", q, snap_q);
        end

        // Read-only register: APB write rejected, hardware load accepted
        apb_xfer(32'h4004, 1'b1, 32'h1234_5678, 4'hF, 8'h0, 32'h0, rd, er, lat);
        check("ro_err", 256'(er), 256'(1));
        check("ro_q1", 256'(q[1]), 256'(RST[1]));
        hw_load(8'h02, 32'h0000_CAFE);
        apb_xfer(32'h4004, 1'b0, 32'h0, 4'h0, 8'h0, 32'h0, rd, er, lat);
        check("ro_rd", 256'(rd), 256'(32'h0000_CAFE));
        check("ro_rd_err", 256'(er), 256'(0));

        // APB write and hardware load to the same register in the same cycle
        apb_xfer(32'h4000, 1'b1, 32'h0000_ABCD, 4'h3, 8'h01, 32'h1234_5678, rd, er, lat);
        check("mix_q0", 256'(q[0]), 256'(32'h1234_ABCD));

        // Zero strobe is an OKAY no-op
        apb_xfer(32'h4010, 1'b1, 32'hFFFF_FFFF, 4'h0, 8'h0, 32'h0, rd, er, lat);
        check("nostrb_err", 256'(er), 256'(0));
        check("nostrb_q4", 256'(q[4]), 256'(RST[4]));

        // psel dropped during ACCESS: no response, no write
        req = '{paddr: 32'h4018, pprot: 3'b0, psel: 1'b1, penable: 1'b0, pwrite: 1'b1,
                pwdata: 32'h6666_6666, pstrb: 4'hF};
        model_start(32'h4018, 1'b1);
        @(posedge clk); #1 req.penable = 1'b1;
        @(posedge clk); #1 req = '0; t_act = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("abort_q6", 256'(q[6]), 256'(RST[6]));

        // Asynchronous reset in the middle of a write
        req = '{paddr: 32'h4014, pprot: 3'b0, psel: 1'b1, penable: 1'b0, pwrite: 1'b1,
                pwdata: 32'h5555_5555, pstrb: 4'hF};
        model_start(32'h4014, 1'b1);
        @(posedge clk); #1 req.penable = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("arst_pready", 256'(rsp.pready), 256'(0));
        check("arst_pslverr", 256'(rsp.pslverr), 256'(0));
        check("arst_prdata", 256'(rsp.prdata), 256'(0));
        check("arst_q", q, RST);
        req = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("arst_q5", 256'(q[5]), 256'(RST[5]));
        apb_xfer(32'h4014, 1'b0, 32'h0, 4'h0, 8'h0, 32'h0, rd, er, lat);
        check("post_rst_rd", 256'(rd), 256'(RST[5]));
        check("post_rst_lat", 256'(lat), 256'(3));
        apb_xfer(32'h4014, 1'b1, 32'h0BAD_F00D, 4'hF, 8'h0, 32'h0, rd, er, lat);
        check("post_rst_q5", 256'(q[5]), 256'(32'h0BAD_F00D));

        // Randomized traffic with occasional hardware loads
        for (int i = 0; i < 250; i++) begin
            sel = int'($urandom_range(0, 11));
            if (sel < 8) ra = BASE + 32'(4 * sel);
            else if (sel == 8) ra = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
            else if (sel == 9) ra = BASE + 32'h20 + 32'(4 * $urandom_range(0, 50));
            else if (sel == 10) ra = BASE - 32'(4 * $urandom_range(1, 10));
            else ra = $urandom;
            apb_xfer(ra, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                     ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0, $urandom, rd, er, lat);
            if ($urandom_range(0, 3) == 0) hw_load(8'($urandom), $urandom);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
